in_out_control: RTL and testbench

// - Switch/key user front-end for the memory controller: operator keys in a 25-bit address (and 16-bit data for writes)
//   8-9 bits at a time from sw, launches a read or write, and waits on memDone.
// - Drives the memory command (modeOutput, memoryAddress, write_data); presents results on displayData/ioDone;

---
 rtl/in_out_control_if.sv | 27 ++
 rtl/in_out_control.sv | 202 ++++++++++++++++++++
 tb/tb_in_out_control.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/in_out_control_if.sv
// Memory command bus between the switch/key front-end (master) and the memory controller (slave).
interface in_out_control_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic [1:0]        modeOutput;
    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] write_data;
    logic              memDone;
    logic [DATA_W-1:0] read_data;

    modport master (
        output modeOutput,
        output memoryAddress,
        output write_data,
        input  memDone,
        input  read_data
    );

    modport slave (
        input  modeOutput,
        input  memoryAddress,
        input  write_data,
        output memDone,
        output read_data
    );
endinterface

// File: rtl/in_out_control.sv
// Switch/key front-end: keys in an address (and write data) from sw, launches a memory access, shows results.
// Optional KEY_EDGE_DETECT_EN: keys are rising-edge detected internally (one registered cycle of delay).
//
// state   | meaning
// IDLE    | waiting for key0 (read) or key1 (write)
// RD_A0   | read, latch address [7:0] on key1
// RD_A1   | read, latch address [15:8] on key1
// RD_A2   | read, latch address [24:16] on key1, then launch
// RD_WAIT | read in flight, modeOutput=01
// RD_DONE | read data captured, ioDone=1 until a key
// WR_A0   | write, latch address [7:0] on key1
// WR_A1   | write, latch address [15:8] on key1
// WR_A2   | write, latch address [24:16] on key1
// WR_D0   | write, latch data [7:0] on key1
// WR_D1   | write, latch data [15:8] on key1, then launch
// WR_WAIT | write in flight, modeOutput=10
module in_out_control #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key0_pulse,
    input  logic               key1_pulse,
    input  logic [8:0]         sw,
    in_out_control_if.master   mem,
    output logic [DATA_W-1:0]  displayData,
    output logic               ioDone,
    output logic [11:0]        out_state
);

    typedef enum logic [11:0] {
        IDLE    = 12'h001,
        RD_A0   = 12'h002,
        RD_A1   = 12'h004,
        RD_A2   = 12'h008,
        RD_WAIT = 12'h010,
        RD_DONE = 12'h020,
        WR_A0   = 12'h040,
        WR_A1   = 12'h080,
        WR_A2   = 12'h100,
        WR_D0   = 12'h200,
        WR_D1   = 12'h400,
        WR_WAIT = 12'h800
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        mode_q, mode_d;
    logic              io_done_q, io_done_d;
    logic              wait_first_q, wait_first_d;
    logic              wait_done;
    logic              key0, key1;

`ifdef KEY_EDGE_DETECT_EN
    logic key0_prev, key1_prev, key0_evt, key1_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            key0_prev <= 1'b0;
            key1_prev <= 1'b0;
            key0_evt  <= 1'b0;
            key1_evt  <= 1'b0;
        end else begin
            key0_prev <= key0_pulse;
            key1_prev <= key1_pulse;
            key0_evt  <= key0_pulse & ~key0_prev;
            key1_evt  <= key1_pulse & ~key1_prev;
        end
    end

    assign key0 = key0_evt;
    assign key1 = key1_evt;
`else
    assign key0 = key0_pulse;
    assign key1 = key1_pulse;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        io_done_d = 1'b0;
        // The memory side may still report idle on the first WAIT cycle, so it is not trusted then.
        wait_done = ~wait_first_q & mem.memDone;

        if (key0 && key1) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key0) begin
                        state_d = RD_A0;
                        addr_d  = '0;
                        wdata_d = '0;
                    end else if (key1) begin
                        state_d = WR_A0;
                        addr_d  = '0;
                        wdata_d = '0;
                    end
                end
                RD_A0, WR_A0: begin
                    if (key1) begin
                        addr_d[7:0] = sw[7:0];
                        state_d     = (state_q == RD_A0) ? RD_A1 : WR_A1;
                    end
                end
                RD_A1, WR_A1: begin
                    if (key1) begin
                        addr_d[15:8] = sw[7:0];
                        state_d      = (state_q == RD_A1) ? RD_A2 : WR_A2;
                    end
                end
                RD_A2, WR_A2: begin
                    if (key1) begin
                        addr_d[ADDR_W-1:16] = sw[ADDR_W-17:0];
                        state_d             = (state_q == RD_A2) ? RD_WAIT : WR_D0;
                    end
                end
                WR_D0: begin
                    if (key1) begin
                        wdata_d[7:0] = sw[7:0];
                        state_d      = WR_D1;
                    end
                end
                WR_D1: begin
                    if (key1) begin
                        wdata_d[DATA_W-1:8] = sw[DATA_W-9:0];
                        state_d             = WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        rdata_d = mem.read_data;
                        state_d = RD_DONE;
                    end
                end
                RD_DONE: begin
                    if (key0 || key1) begin
                        state_d = IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        state_d   = IDLE;
                        io_done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Command and status are registered from the next state so they line up with out_state.
        if (state_d == RD_WAIT) begin
            mode_d = 2'b01;
        end else if (state_d == WR_WAIT) begin
            mode_d = 2'b10;
        end else begin
            mode_d = 2'b00;
        end
        io_done_d    = io_done_d | (state_d == RD_DONE);
        wait_first_d = ((state_d == RD_WAIT) || (state_d == WR_WAIT)) && (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mode_q       <= 2'b00;
            io_done_q    <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mode_q       <= mode_d;
            io_done_q    <= io_done_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign mem.modeOutput    = mode_q;
    assign mem.memoryAddress = addr_q;
    assign mem.write_data    = wdata_q;
    assign ioDone            = io_done_q;
    assign out_state         = state_q;
    assign displayData       = (state_q inside {WR_A0, WR_A1, WR_A2, WR_D0, WR_D1, WR_WAIT})
                               ? wdata_q : rdata_q;

endmodule

// File: tb/tb_in_out_control.sv
// Bench for in_out_control: directed scenarios plus random key/switch/memory traffic against a behavioural model.
module tb_in_out_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        key0_pulse, key1_pulse;
    logic [8:0]  sw;
    logic [15:0] displayData;
    logic        ioDone;
    logic [11:0] out_state;

    int n_checks = 0;
    int n_errors = 0;

    in_out_control_if #(.ADDR_W(25), .DATA_W(16)) mem_bus ();

    in_out_control #(.ADDR_W(25), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .key0_pulse (key0_pulse),
        .key1_pulse (key1_pulse),
        .sw         (sw),
        .mem        (mem_bus.master),
        .displayData(displayData),
        .ioDone     (ioDone),
        .out_state  (out_state)
    );

    always #5 clk = ~clk;

    // Model state numbering follows the out_state bit positions.
    localparam int S_IDLE = 0, S_RA0 = 1, S_RA1 = 2, S_RA2 = 3, S_RWAIT = 4, S_RDONE = 5;
    localparam int S_WA0 = 6, S_WA1 = 7, S_WA2 = 8, S_WD0 = 9, S_WD1 = 10, S_WWAIT = 11;

    int          m_st;
    logic [24:0] m_addr;
    logic [15:0] m_wd, m_rd;
    logic [1:0]  m_mode;
    logic        m_io;
    bit          m_fresh;
    bit          m_k0_prev, m_k1_prev, m_k0_evt, m_k1_evt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit k0, k1;
        int ns;
        bit io;
`ifdef KEY_EDGE_DETECT_EN
        k0 = m_k0_evt;
        k1 = m_k1_evt;
        m_k0_evt  = key0_pulse && !m_k0_prev;
        m_k1_evt  = key1_pulse && !m_k1_prev;
        m_k0_prev = key0_pulse;
        m_k1_prev = key1_pulse;
`else
        k0 = key0_pulse;
        k1 = key1_pulse;
`endif
        if (reset) begin
            m_st = S_IDLE; m_addr = 0; m_wd = 0; m_rd = 0; m_mode = 0; m_io = 0; m_fresh = 0;
            m_k0_prev = 0; m_k1_prev = 0; m_k0_evt = 0; m_k1_evt = 0;
            return;
        end
        ns = m_st;
        io = 0;
        if (k0 && k1) begin
            ns = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE: if (k0 || k1) begin
                    ns = k0 ? S_RA0 : S_WA0;
                    m_addr = 0;
                    m_wd = 0;
                end
                S_RA0, S_WA0: if (k1) begin
                    m_addr = (m_addr & ~25'hFF) | 25'(sw & 9'hFF);
                    ns = m_st + 1;
                end
                S_RA1, S_WA1: if (k1) begin
                    m_addr = (m_addr & ~25'hFF00) | (25'(sw & 9'hFF) << 8);
                    ns = m_st + 1;
                end
                S_RA2, S_WA2: if (k1) begin
                    m_addr = (m_addr & 25'hFFFF) | (25'(sw) << 16);
                    ns = m_st + 1;
                end
                S_WD0: if (k1) begin
                    m_wd = (m_wd & 16'hFF00) | 16'(sw & 9'hFF);
                    ns = S_WD1;
                end
                S_WD1: if (k1) begin
                    m_wd = (m_wd & 16'h00FF) | (16'(sw & 9'hFF) << 8);
                    ns = S_WWAIT;
                end
                S_RWAIT: if (!m_fresh && mem_bus.memDone) begin
                    m_rd = mem_bus.read_data;
                    ns = S_RDONE;
                end
                S_RDONE: if (k0 || k1) ns = S_IDLE;
                S_WWAIT: if (!m_fresh && mem_bus.memDone) begin
                    ns = S_IDLE;
                    io = 1;
                end
                default: ns = S_IDLE;
            endcase
        end
        m_fresh = (ns == S_RWAIT || ns == S_WWAIT) && ns != m_st;
        m_mode  = (ns == S_RWAIT) ? 2'b01 : (ns == S_WWAIT) ? 2'b10 : 2'b00;
        m_io    = io || ns == S_RDONE;
        m_st    = ns;
    endtask

    task automatic compare_all();
        logic [15:0] exp_disp;
        exp_disp = (m_st >= S_WA0) ? m_wd : m_rd;
        check_val("out_state", 32'(out_state), 32'(12'h001 << m_st));
        check_val("modeOutput", 32'(mem_bus.modeOutput), 32'(m_mode));
        check_val("memoryAddress", 32'(mem_bus.memoryAddress), 32'(m_addr));
        check_val("write_data", 32'(mem_bus.write_data), 32'(m_wd));
        check_val("displayData", 32'(displayData), 32'(exp_disp));
        check_val("ioDone", 32'(ioDone), 32'(m_io));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // One key press; in the edge-detect build an extra cycle lets the registered event act.
    task automatic press(input bit k0, input bit k1, input logic [8:0] sw_v);
        sw = sw_v;
        key0_pulse = k0;
        key1_pulse = k1;
        tick();
        key0_pulse = 0;
        key1_pulse = 0;
`ifdef KEY_EDGE_DETECT_EN
        tick();
`endif
    endtask

    initial begin
        reset = 1; key0_pulse = 0; key1_pulse = 0; sw = 0;
        mem_bus.memDone = 1; mem_bus.read_data = 0;
        tick();
        reset = 0;
        check_val("rst_state", 32'(out_state), 32'h001);
        check_val("rst_mode", 32'(mem_bus.modeOutput), 32'h0);
        check_val("rst_addr", 32'(mem_bus.memoryAddress), 32'h0);
        check_val("rst_iodone", 32'(ioDone), 32'h0);

        // Read of 1FFFFFF
        press(1, 0, 9'h000);
        press(0, 1, 9'h0FF);
        press(0, 1, 9'h0FF);
        mem_bus.memDone = 0;
        press(0, 1, 9'h1FF);
        check_val("rd_wait_state", 32'(out_state), 32'h010);
        check_val("rd_addr", 32'(mem_bus.memoryAddress), 32'h1FFFFFF);
        check_val("rd_mode", 32'(mem_bus.modeOutput), 32'h1);
        mem_bus.read_data = 16'hAAAA;
        mem_bus.memDone = 1;
        tick();
        tick();
        check_val("rd_done_state", 32'(out_state), 32'h020);
        check_val("rd_disp", 32'(displayData), 32'hAAAA);
        check_val("rd_iodone", 32'(ioDone), 32'h1);
        check_val("rd_done_mode", 32'(mem_bus.modeOutput), 32'h0);
        press(1, 0, 9'h000);
        check_val("rd_ack_state", 32'(out_state), 32'h001);

        // Write ABCD to 0011234
        press(0, 1, 9'h000);
        press(0, 1, 9'h034);
        press(0, 1, 9'h012);
        press(0, 1, 9'h001);
        press(0, 1, 9'h0CD);
        mem_bus.memDone = 0;
        press(0, 1, 9'h0AB);
        check_val("wr_wait_state", 32'(out_state), 32'h800);
        check_val("wr_addr", 32'(mem_bus.memoryAddress), 32'h0011234);
        check_val("wr_data", 32'(mem_bus.write_data), 32'hABCD);
        check_val("wr_mode", 32'(mem_bus.modeOutput), 32'h2);
        mem_bus.memDone = 1;
        tick();
        check_val("wr_first_ignored", 32'(out_state), 32'h800);
        tick();
        check_val("wr_end_state", 32'(out_state), 32'h001);
        check_val("wr_iodone_hi", 32'(ioDone), 32'h1);
        tick();
        check_val("wr_iodone_lo", 32'(ioDone), 32'h0);
        check_val("wr_addr_hold", 32'(mem_bus.memoryAddress), 32'h0011234);

        // Abort in RD_A1, then in RD_WAIT
        press(1, 0, 9'h000);
        press(0, 1, 9'h077);
        press(1, 1, 9'h000);
        check_val("abort_a1_state", 32'(out_state), 32'h001);
        check_val("abort_a1_disp", 32'(displayData), 32'hAAAA);
        check_val("abort_a1_addr", 32'(mem_bus.memoryAddress), 32'h77);
        press(1, 0, 9'h000);
        press(0, 1, 9'h011);
        press(0, 1, 9'h022);
        mem_bus.memDone = 0;
        press(0, 1, 9'h033);
        check_val("abort_wait_pre", 32'(mem_bus.modeOutput), 32'h1);
        press(1, 1, 9'h000);
        check_val("abort_wait_state", 32'(out_state), 32'h001);
        check_val("abort_wait_mode", 32'(mem_bus.modeOutput), 32'h0);
        check_val("abort_wait_disp", 32'(displayData), 32'hAAAA);

        // memDone stuck high across entry into RD_WAIT
        mem_bus.memDone = 1;
        mem_bus.read_data = 16'h5A5A;
        press(1, 0, 9'h000);
        press(0, 1, 9'h001);
        press(0, 1, 9'h002);
        press(0, 1, 9'h003);
        check_val("stuck_enter", 32'(out_state), 32'h010);
        tick();
        check_val("stuck_hold", 32'(out_state), 32'h010);
        tick();
        check_val("stuck_done", 32'(out_state), 32'h020);
        check_val("stuck_disp", 32'(displayData), 32'h5A5A);
        press(0, 1, 9'h000);

`ifdef KEY_EDGE_DETECT_EN
        key0_pulse = 1;
        repeat (3) tick();
        key0_pulse = 0;
        tick();
        check_val("edge_key0_once", 32'(out_state), 32'h002);
        sw = 9'h055;
        key1_pulse = 1;
        repeat (3) tick();
        key1_pulse = 0;
        tick();
        check_val("edge_key1_once", 32'(out_state), 32'h004);
        check_val("edge_key1_addr", 32'(mem_bus.memoryAddress), 32'h55);
        press(1, 1, 9'h000);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            key0_pulse = (r < 12) || (r >= 97);
            key1_pulse = (r >= 12 && r < 40) || (r >= 97);
            sw = 9'($urandom_range(0, 511));
            mem_bus.memDone = ($urandom_range(0, 9) < 4);
            mem_bus.read_data = 16'($urandom);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 0;
        key0_pulse = 0;
        key1_pulse = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
